bcd_serial_add_ctrl: RTL

Sequencer that performs multi-digit packed-BCD addition by time-multiplexing a single 4-bit `bcd_adder` digit cell. It accepts two NUM_DIGITS-digit operands plus a carry-in on a start/busy/done handshake. It feeds one digit pair per cycle, least-significant first, through the shared digit cell, and registers the digit carry between cycles. It sits between register-mapped operand storage and any consumer of the decimal sum, trading latency for area.

---
 rtl/bcd_pkg.sv | 13 +
 rtl/bcd_adder.sv | 23 ++
 rtl/bcd_serial_add_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the serial packed-BCD adder: digit width, largest legal
// digit value and the sequencer state encoding.
package bcd_pkg;

    localparam int         BCD_DIGIT_W   = 4;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_adder.sv
// Single-digit BCD adder cell: binary add with carry, then +6 correction when
// the binary sum overflows 4 bits or exceeds 9. Invalid digits are not masked.
module bcd_adder
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a,
    input  logic [BCD_DIGIT_W-1:0] b,
    input  logic                   cin,
    output logic [BCD_DIGIT_W-1:0] sum,
    output logic                   cout
);

    logic [BCD_DIGIT_W:0] bin_sum;
    logic                 correct;

    always_comb begin
        bin_sum = {1'b0, a} + {1'b0, b} + {{BCD_DIGIT_W{1'b0}}, cin};
        correct = bin_sum[BCD_DIGIT_W] || (bin_sum[BCD_DIGIT_W-1:0] > BCD_MAX_DIGIT);
        sum     = correct ? (bin_sum[BCD_DIGIT_W-1:0] + 4'd6) : bin_sum[BCD_DIGIT_W-1:0];
        cout    = correct;
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit packed-BCD adder that feeds one digit pair per cycle, LSD first,
// through a shared bcd_adder cell. Optional invalid-digit flag: BCD_SEQ_VALIDATE_EN.
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] operand_a,
    input  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] operand_b,
    input  logic                            carry_in,
    output logic                            busy,
    output logic                            done,
    output logic [BCD_DIGIT_W*NUM_DIGITS-1:0] result,
    output logic                            carry_out,
    output logic                            err
);

    localparam int W     = BCD_DIGIT_W * NUM_DIGITS;
    localparam int CNT_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

    state_t                   state;
    state_t                   state_next;
    logic                     accept;
    logic                     last_digit;
    logic [W-1:0]             a_sr;
    logic [W-1:0]             b_sr;
    logic [W-1:0]             res_sr;
    logic                     carry_r;
    logic [CNT_W-1:0]         cnt;
    logic [BCD_DIGIT_W-1:0]   cell_sum;
    logic                     cell_carry;

    bcd_adder u_cell (
        .a    (a_sr[BCD_DIGIT_W-1:0]),
        .b    (b_sr[BCD_DIGIT_W-1:0]),
        .cin  (carry_r),
        .sum  (cell_sum),
        .cout (cell_carry)
    );

    assign busy = (state == S_RUN);

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_digit = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt == LAST_CNT) begin
                    last_digit = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            carry_r   <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            if (accept) begin
                a_sr    <= operand_a;
                b_sr    <= operand_b;
                carry_r <= carry_in;
                cnt     <= '0;
                res_sr  <= '0;
            end else if (state == S_RUN) begin
                // New digit enters at the top so digit 0 ends up in the low nibble.
                res_sr  <= {cell_sum, res_sr[W-1:BCD_DIGIT_W]};
                a_sr    <= {{BCD_DIGIT_W{1'b0}}, a_sr[W-1:BCD_DIGIT_W]};
                b_sr    <= {{BCD_DIGIT_W{1'b0}}, b_sr[W-1:BCD_DIGIT_W]};
                carry_r <= cell_carry;
                if (!last_digit) begin
                    cnt <= cnt + CNT_W'(1);
                end
                if (last_digit) begin
                    result    <= {cell_sum, res_sr[W-1:BCD_DIGIT_W]};
                    carry_out <= cell_carry;
                    done      <= 1'b1;
                end
            end
        end
    end

`ifdef BCD_SEQ_VALIDATE_EN
    logic digit_bad;
    logic bad_flag;

    assign digit_bad = (a_sr[BCD_DIGIT_W-1:0] > BCD_MAX_DIGIT) ||
                       (b_sr[BCD_DIGIT_W-1:0] > BCD_MAX_DIGIT);

    // Sticky per operation; the final digit is folded in directly at the done edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            bad_flag <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (accept) begin
                bad_flag <= 1'b0;
            end else if ((state == S_RUN) && digit_bad) begin
                bad_flag <= 1'b1;
            end
            if (last_digit) begin
                err <= bad_flag || digit_bad;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
